// File: rtl/vo_timing_pkg.sv
// Shared timing constants and FSM encoding for the video-out timing generator.
package vo_timing_pkg;

  // 1280x720p60 raster defaults
  localparam int H_DISP_DEF    = 1280;
  localparam int H_FP_DEF      = 110;
  localparam int H_SYNC_DEF    = 40;
  localparam int H_BP_DEF      = 220;
  localparam int V_DISP_DEF    = 720;
  localparam int V_FP_DEF      = 5;
  localparam int V_SYNC_DEF    = 5;
  localparam int V_BP_DEF      = 20;
  localparam int CNT_WIDTH_DEF = 12;

  // Full period of a line or frame from its four segments
  function automatic int calc_total(input int disp, input int fp, input int sync, input int bp);
    return disp + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = calc_total(H_DISP_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = calc_total(V_DISP_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vo_state_e;

endpackage

// File: rtl/vo_raster_cnt.sv
// Horizontal/vertical raster counters and stage-0 region decode.
// Counters only advance while i_run is high and sit at (0,0) otherwise,
// so all region flags are forced inactive while the generator is idle.
module vo_raster_cnt
  import vo_timing_pkg::*;
#(
  parameter int H_DISP    = H_DISP_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISP    = V_DISP_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  output logic o_frame_end,
  output logic o_active,
  output logic o_hs_a,
  output logic o_vs_a
);

  localparam int H_TOTAL = calc_total(H_DISP, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_DISP, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_WIDTH-1:0] H_LAST     = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_LAST     = CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT_END  = CNT_WIDTH'(H_DISP);
  localparam logic [CNT_WIDTH-1:0] V_ACT_END  = CNT_WIDTH'(V_DISP);
  localparam logic [CNT_WIDTH-1:0] HS_START   = CNT_WIDTH'(H_DISP + H_FP);
  localparam logic [CNT_WIDTH-1:0] HS_END     = CNT_WIDTH'(H_DISP + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] VS_START   = CNT_WIDTH'(V_DISP + V_FP);
  localparam logic [CNT_WIDTH-1:0] VS_END     = CNT_WIDTH'(V_DISP + V_FP + V_SYNC);

  logic [CNT_WIDTH-1:0] r_h_cnt;
  logic [CNT_WIDTH-1:0] r_v_cnt;
  logic                 w_line_end;
  logic                 w_frame_end;

  assign w_line_end  = (r_h_cnt == H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == V_LAST);

  // Advance h every clock while running; v steps on each h wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (!i_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      if (w_frame_end) begin
        r_v_cnt <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 1'b1;
      end
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_frame_end = i_run && w_frame_end;
  assign o_active    = i_run && (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign o_hs_a      = i_run && (r_h_cnt >= HS_START) && (r_h_cnt < HS_END);
  assign o_vs_a      = i_run && (r_v_cnt >= VS_START) && (r_v_cnt < VS_END);

endmodule

// File: rtl/vo_timing_gen.sv
// Display-side raster timing generator: pulls RGB565 pixels from the output
// FIFO and emits hs/vs/de/data for the encoder, two clocks behind the counters.
// Start/stop requests take effect only on frame boundaries.
module vo_timing_gen
  import vo_timing_pkg::*;
#(
  parameter int          H_DISP          = H_DISP_DEF,
  parameter int          H_FP            = H_FP_DEF,
  parameter int          H_SYNC          = H_SYNC_DEF,
  parameter int          H_BP            = H_BP_DEF,
  parameter int          V_DISP          = V_DISP_DEF,
  parameter int          V_FP            = V_FP_DEF,
  parameter int          V_SYNC          = V_SYNC_DEF,
  parameter int          V_BP            = V_BP_DEF,
  parameter logic        HS_POL          = 1'b1,
  parameter logic        VS_POL          = 1'b1,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'h0000,
  parameter int          CNT_WIDTH       = CNT_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd_en,
  output logic        frame_start,
  output logic        vo_hs,
  output logic        vo_vs,
  output logic        vo_de,
  output logic [15:0] vo_data,
  output logic        underflow,
  input  logic        underflow_clr
);

  vo_state_e r_state;
  vo_state_e w_state_next;
  logic      w_frame_start_next;
  logic      r_frame_start;

  logic      w_run;
  logic      w_frame_end;
  logic      w_active;
  logic      w_hs_a;
  logic      w_vs_a;
  logic      w_rd_en;

  // Stage 1
  logic      r_active_d1;
  logic      r_hs_a_d1;
  logic      r_vs_a_d1;
  logic      r_rd_ok_d1;
  logic      r_miss_d1;

  // Stage 2 (output registers)
  logic        r_vo_de;
  logic        r_vo_hs;
  logic        r_vo_vs;
  logic [15:0] r_vo_data;
  logic        r_underflow;

  assign w_run = (r_state != ST_IDLE);

  vo_raster_cnt #(
    .H_DISP    (H_DISP),
    .H_FP      (H_FP),
    .H_SYNC    (H_SYNC),
    .H_BP      (H_BP),
    .V_DISP    (V_DISP),
    .V_FP      (V_FP),
    .V_SYNC    (V_SYNC),
    .V_BP      (V_BP),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_raster_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_run       (w_run),
    .o_frame_end (w_frame_end),
    .o_active    (w_active),
    .o_hs_a      (w_hs_a),
    .o_vs_a      (w_vs_a)
  );

  // Read only real active pixels; an empty FIFO means that pixel is skipped, never re-read
  assign w_rd_en = w_active && !fifo_empty;

  // State register plus the frame_start pulse that accompanies entry to (0,0)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  // Next state: run requests honoured immediately from idle, stops deferred to frame end
  always_comb begin
    w_state_next       = r_state;
    w_frame_start_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_next       = ST_RUN;
          w_frame_start_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (!en) begin
          // A stop seen on the very last clock of a frame needs no extra frame
          w_state_next = w_frame_end ? ST_IDLE : ST_STOPPING;
        end else if (w_frame_end) begin
          w_frame_start_next = 1'b1;
        end
      end
      ST_STOPPING: begin
        if (en) begin
          w_state_next       = ST_RUN;
          w_frame_start_next = w_frame_end;
        end else if (w_frame_end) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Stage 1: capture region flags alongside the read strobe the FIFO answers next clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active_d1 <= 1'b0;
      r_hs_a_d1   <= 1'b0;
      r_vs_a_d1   <= 1'b0;
      r_rd_ok_d1  <= 1'b0;
      r_miss_d1   <= 1'b0;
    end else begin
      r_active_d1 <= w_active;
      r_hs_a_d1   <= w_hs_a;
      r_vs_a_d1   <= w_vs_a;
      r_rd_ok_d1  <= w_rd_en;
      r_miss_d1   <= w_active && fifo_empty;
    end
  end

  // Stage 2: aligned output registers; missed active pixels get the fill colour
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vo_de   <= 1'b0;
      r_vo_hs   <= ~HS_POL;
      r_vo_vs   <= ~VS_POL;
      r_vo_data <= 16'h0000;
    end else begin
      r_vo_de   <= r_active_d1;
      r_vo_hs   <= r_hs_a_d1 ? HS_POL : ~HS_POL;
      r_vo_vs   <= r_vs_a_d1 ? VS_POL : ~VS_POL;
      if (r_rd_ok_d1) begin
        r_vo_data <= fifo_data;
      end else if (r_active_d1) begin
        r_vo_data <= UNDERFLOW_COLOR;
      end else begin
        r_vo_data <= 16'h0000;
      end
    end
  end

  // Sticky underflow flag; a new miss wins over a clear in the same clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (r_miss_d1) begin
      r_underflow <= 1'b1;
    end else if (underflow_clr) begin
      r_underflow <= 1'b0;
    end
  end

  assign fifo_rd_en  = w_rd_en;
  assign frame_start = r_frame_start;
  assign vo_hs       = r_vo_hs;
  assign vo_vs       = r_vo_vs;
  assign vo_de       = r_vo_de;
  assign vo_data     = r_vo_data;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_vo_timing_gen.sv
// Directed bench for vo_timing_gen on a shrunken 14x7 raster.
// dut_p uses active-high syncs, dut_n active-low; both share the FIFO model.
module tb_vo_timing_gen;

  localparam logic [15:0] UF = 16'hF81F;
  localparam int NK = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        fifo_empty = 1'b0;
  logic        underflow_clr = 1'b0;
  logic [15:0] fifo_data = 16'h0000;
  logic [15:0] fifo_word = 16'h0000;

  logic        p_rd, p_fs, p_hs, p_vs, p_de, p_uf;
  logic [15:0] p_data;
  logic        n_rd, n_fs, n_hs, n_vs, n_de, n_uf;
  logic [15:0] n_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rec_de [NK];
  logic        rec_hs [NK];
  logic        rec_vs [NK];
  logic        rec_fs [NK];
  logic        rec_rd [NK];
  logic        rec_nhs[NK];
  logic        rec_nvs[NK];
  logic [15:0] rec_data[NK];

  always #5 clk = ~clk;

  // Normal-mode FIFO: word appears the clock after the read strobe
  always @(posedge clk) begin
    if (p_rd) begin
      fifo_data <= fifo_word;
      fifo_word <= fifo_word + 16'd1;
    end
  end

  vo_timing_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .UNDERFLOW_COLOR(UF), .CNT_WIDTH(12)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(p_rd), .frame_start(p_fs), .vo_hs(p_hs), .vo_vs(p_vs), .vo_de(p_de),
    .vo_data(p_data), .underflow(p_uf), .underflow_clr(underflow_clr)
  );

  vo_timing_gen #(
    .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .UNDERFLOW_COLOR(UF), .CNT_WIDTH(12)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(n_rd), .frame_start(n_fs), .vo_hs(n_hs), .vo_vs(n_vs), .vo_de(n_de),
    .vo_data(n_data), .underflow(n_uf), .underflow_clr(underflow_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int exp_word;
    int n_bad;
    int cnt;
    int guard;
    int n_idle_act;
    int n_fs_mid;
    logic [15:0] w0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_de",    32'(p_de),   32'd0);
    check("rst_data",  32'(p_data), 32'd0);
    check("rst_hs",    32'(p_hs),   32'd0);
    check("rst_vs",    32'(p_vs),   32'd0);
    check("rst_rd",    32'(p_rd),   32'd0);
    check("rst_fs",    32'(p_fs),   32'd0);
    check("rst_uf",    32'(p_uf),   32'd0);
    check("rst_n_hs",  32'(n_hs),   32'd1);
    check("rst_n_vs",  32'(n_vs),   32'd1);
    check("rst_n_misc", 32'({n_de, n_rd, n_fs, n_uf}), 32'd0);
    check("rst_n_data", 32'(n_data), 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(negedge clk);

    // ---------------- record two-plus frames, FIFO never empty ----------------
    for (int k = 0; k < NK; k++) begin
      rec_de[k]   = p_de;
      rec_hs[k]   = p_hs;
      rec_vs[k]   = p_vs;
      rec_fs[k]   = p_fs;
      rec_rd[k]   = p_rd;
      rec_nhs[k]  = n_hs;
      rec_nvs[k]  = n_vs;
      rec_data[k] = p_data;
      @(negedge clk);
    end

    check("fs_first",   32'(rec_fs[0]),   32'd1);
    check("fs_period",  32'(rec_fs[98]),  32'd1);
    cnt = 0;
    for (int k = 0; k < NK; k++) cnt += int'(rec_fs[k]);
    check("fs_count",   32'(cnt),         32'd3);
    check("de_lat_k1",  32'(rec_de[1]),   32'd0);
    check("de_lat_k2",  32'(rec_de[2]),   32'd1);
    check("first_pix",  32'(rec_data[2]), 32'd0);

    n_bad = 0;
    for (int l = 0; l < 7; l++) begin
      cnt = 0;
      for (int j = 0; j < 14; j++) cnt += int'(rec_de[2 + 14*l + j]);
      if (cnt != ((l < 4) ? 8 : 0)) n_bad++;
    end
    check("de_per_line", 32'(n_bad), 32'd0);

    exp_word = 0;
    n_bad    = 0;
    for (int k = 0; k < NK; k++) begin
      if (rec_de[k]) begin
        if (rec_data[k] != 16'(exp_word)) n_bad++;
        exp_word++;
      end
    end
    check("stream_order", 32'(n_bad),    32'd0);
    check("stream_count", 32'(exp_word), 32'd66);

    cnt = 0;
    for (int k = 0; k < 98; k++) cnt += int'(rec_rd[k]);
    check("rd_per_frame", 32'(cnt), 32'd32);

    check("hs_k11", 32'(rec_hs[11]), 32'd0);
    check("hs_k12", 32'(rec_hs[12]), 32'd1);
    check("hs_k13", 32'(rec_hs[13]), 32'd1);
    check("hs_k14", 32'(rec_hs[14]), 32'd0);
    check("vs_k71", 32'(rec_vs[71]), 32'd0);
    check("vs_k72", 32'(rec_vs[72]), 32'd1);
    check("vs_k85", 32'(rec_vs[85]), 32'd1);
    check("vs_k86", 32'(rec_vs[86]), 32'd0);

    cnt = 0;
    for (int k = 2; k < 16; k++) cnt += int'(!rec_nhs[k]);
    check("nhs_low_len", 32'(cnt),          32'd2);
    check("nhs_k12",     32'(rec_nhs[12]),  32'd0);
    cnt = 0;
    for (int k = 2; k < 100; k++) cnt += int'(!rec_nvs[k]);
    check("nvs_low_len", 32'(cnt),          32'd14);

    // ---------------- align to a frame start ----------------
    guard = 0;
    while (!p_fs && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("sync_fs", 32'(p_fs), 32'd1);
    w0 = fifo_word;
    n_idle_act = 0;
    n_fs_mid   = 0;

    // idx = clocks since the counters reached (0,0)
    for (int idx = 0; idx <= 220; idx++) begin
      // underflow burst on line 1, pixels h=3..5
      if (idx == 16) begin
        check("uf_pre",   32'(p_uf),   32'd0);
        check("rd_ok",    32'(p_rd),   32'd1);
        check("pix_h0",   32'(p_data), 32'(w0 + 16'd8));
      end
      if (idx == 18) begin
        check("pix_h2",   32'(p_data), 32'(w0 + 16'd10));
        check("rd_empty", 32'(p_rd),   32'd0);
      end
      if (idx == 19) check("rd_empty2", 32'(p_rd), 32'd0);
      if (idx >= 19 && idx <= 21) begin
        check("uf_pix",   32'(p_data), 32'(UF));
        check("uf_de",    32'(p_de),   32'd1);
      end
      if (idx == 20) check("uf_set",  32'(p_uf),   32'd1);
      if (idx == 22) check("pix_h6",  32'(p_data), 32'(w0 + 16'd11));
      if (idx == 23) begin
        check("pix_h7",   32'(p_data), 32'(w0 + 16'd12));
        check("uf_clr",   32'(p_uf),   32'd0);
      end
      if (idx == 29) check("uf_pre2", 32'(p_uf), 32'd0);
      if (idx == 30) check("uf_set_prio", 32'(p_uf), 32'd1);

      // stop request mid-frame: frame finishes, then idle
      if (idx == 44) check("stop_de",  32'(p_de), 32'd1);
      if (idx == 73) check("stop_vs",  32'(p_vs), 32'd1);
      if (idx == 98) begin
        check("stop_no_fs", 32'(p_fs), 32'd0);
        check("stop_no_rd", 32'(p_rd), 32'd0);
      end
      if (idx >= 100 && idx < 110) n_idle_act += int'(p_de | p_hs | p_vs | p_rd | p_fs);
      if (idx == 105) check("idle_nhs", 32'(n_hs), 32'd1);
      if (idx == 110) check("idle_quiet", 32'(n_idle_act), 32'd0);

      // restart, then stop/re-run within one frame
      if (idx == 111) check("restart_fs", 32'(p_fs), 32'd1);
      if (idx == 112) check("restart_de0", 32'(p_de), 32'd0);
      if (idx == 113) check("restart_de1", 32'(p_de), 32'd1);
      if (idx >= 112 && idx < 209) n_fs_mid += int'(p_fs);
      if (idx == 209) begin
        check("rerun_no_fs", 32'(n_fs_mid), 32'd0);
        check("rerun_fs",    32'(p_fs),     32'd1);
      end
      if (idx == 211) check("rerun_de", 32'(p_de), 32'd1);

      // reset mid-line
      if (idx == 215) begin
        check("pre_rst_de", 32'(p_de), 32'd1);
        check("pre_rst_uf", 32'(p_uf), 32'd1);
      end
      if (idx == 216) begin
        check("mrst_de",   32'(p_de),   32'd0);
        check("mrst_data", 32'(p_data), 32'd0);
        check("mrst_hs",   32'(p_hs),   32'd0);
        check("mrst_vs",   32'(p_vs),   32'd0);
        check("mrst_rd",   32'(p_rd),   32'd0);
        check("mrst_fs",   32'(p_fs),   32'd0);
        check("mrst_uf",   32'(p_uf),   32'd0);
        check("mrst_nhs",  32'(n_hs),   32'd1);
      end
      if (idx == 217) check("post_rst_fs",  32'(p_fs), 32'd1);
      if (idx == 218) check("post_rst_fs0", 32'(p_fs), 32'd0);
      if (idx == 219) check("post_rst_de",  32'(p_de), 32'd1);

      // input drive for the next clock edge
      case (idx)
        17:  fifo_empty    = 1'b1;
        20:  fifo_empty    = 1'b0;
        22:  underflow_clr = 1'b1;
        23:  underflow_clr = 1'b0;
        28:  fifo_empty    = 1'b1;
        29:  begin fifo_empty = 1'b0; underflow_clr = 1'b1; end
        30:  underflow_clr = 1'b0;
        40:  en            = 1'b0;
        110: en            = 1'b1;
        130: en            = 1'b0;
        150: en            = 1'b1;
        215: rst_n         = 1'b0;
        216: rst_n         = 1'b1;
        default: ;
      endcase
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
